// File: rtl/mac_accum_param_3_pkg.sv
// Shared constants and helpers for the layer-3 MAC engine.
// Optional bias input is controlled by the MAC_BIAS_EN macro (see interface/top).
package mac_accum_param_3_pkg;

  localparam int DEF_DATA_WIDTH           = 16;
  localparam int DEF_ACCUM_DATA_WIDTH     = 32;
  localparam int DEF_COUNT_SLOAD_BITWIDTH = 5;
  localparam int DEF_KERNEL_TAPS          = 25;

  // Tap index that follows eff_tap in a window of 'taps' products.
  function automatic int tap_after(input int eff_tap, input int taps);
    return (eff_tap == taps - 1) ? 0 : eff_tap + 1;
  endfunction

endpackage

// File: rtl/mac_accum_param_3_if.sv
// Operand/result bundle for mac_accum_param_3.
// bias_in exists only when MAC_BIAS_EN is defined.
interface mac_accum_param_3_if
  import mac_accum_param_3_pkg::*;
#(
  parameter int DATA_WIDTH           = DEF_DATA_WIDTH,
  parameter int ACCUM_DATA_WIDTH     = DEF_ACCUM_DATA_WIDTH,
  parameter int COUNT_SLOAD_BITWIDTH = DEF_COUNT_SLOAD_BITWIDTH
);
  logic                               enable;
  logic                               start;
  logic signed [DATA_WIDTH-1:0]       data_in;
  logic signed [DATA_WIDTH-1:0]       weight_in;
`ifdef MAC_BIAS_EN
  logic signed [ACCUM_DATA_WIDTH-1:0] bias_in;
`endif
  logic signed [ACCUM_DATA_WIDTH-1:0] result;
  logic [COUNT_SLOAD_BITWIDTH-1:0]    count_sload;

  modport master (
    output enable, output start, output data_in, output weight_in,
`ifdef MAC_BIAS_EN
    output bias_in,
`endif
    input  result, input count_sload
  );

  modport slave (
    input  enable, input start, input data_in, input weight_in,
`ifdef MAC_BIAS_EN
    input  bias_in,
`endif
    output result, output count_sload
  );
endinterface

// File: rtl/mac_accum_param_3_mult.sv
// Stage 1 of the MAC: registered full-width signed product, sign-extended
// to the accumulator width.
module mult_reg_param_3
  import mac_accum_param_3_pkg::*;
#(
  parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int ACCUM_DATA_WIDTH = DEF_ACCUM_DATA_WIDTH
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               enable,
  input  logic signed [DATA_WIDTH-1:0]       data_in,
  input  logic signed [DATA_WIDTH-1:0]       weight_in,
  output logic signed [ACCUM_DATA_WIDTH-1:0] prod_r
);
  logic signed [2*DATA_WIDTH-1:0] product;

  // Widen both operands first so the product keeps all 2*DATA_WIDTH bits.
  assign product = (2*DATA_WIDTH)'(data_in) * (2*DATA_WIDTH)'(weight_in);

  always_ff @(posedge clock) begin
    if (reset) begin
      prod_r <= '0;
    end else if (enable) begin
      prod_r <= ACCUM_DATA_WIDTH'(product);
    end
  end
endmodule

// File: rtl/mac_accum_param_3.sv
// Layer-3 signed multiply-accumulate: tap counter, sload flag, accumulator and
// result register. Optional bias on the tap-0 load via MAC_BIAS_EN.
module mac_accum_param_3
  import mac_accum_param_3_pkg::*;
#(
  parameter int DATA_WIDTH           = DEF_DATA_WIDTH,
  parameter int ACCUM_DATA_WIDTH     = DEF_ACCUM_DATA_WIDTH,
  parameter int COUNT_SLOAD_BITWIDTH = DEF_COUNT_SLOAD_BITWIDTH,
  parameter int KERNEL_TAPS          = DEF_KERNEL_TAPS
) (
  input  logic                clock,
  input  logic                reset,
  mac_accum_param_3_if.slave  bus
);
  if (KERNEL_TAPS < 3 || KERNEL_TAPS > (1 << COUNT_SLOAD_BITWIDTH)) begin : g_bad_taps
    $error("KERNEL_TAPS out of range for COUNT_SLOAD_BITWIDTH");
  end

  logic [COUNT_SLOAD_BITWIDTH-1:0]    count_reg;
  logic [COUNT_SLOAD_BITWIDTH-1:0]    count_next;
  logic [COUNT_SLOAD_BITWIDTH-1:0]    eff_tap;
  logic                               sload_r;
  logic signed [ACCUM_DATA_WIDTH-1:0] prod_r;
  logic signed [ACCUM_DATA_WIDTH-1:0] load_value;
  logic signed [ACCUM_DATA_WIDTH-1:0] acc_reg;
  logic signed [ACCUM_DATA_WIDTH-1:0] acc_next;
  logic signed [ACCUM_DATA_WIDTH-1:0] result_reg;

  mult_reg_param_3 #(
    .DATA_WIDTH       (DATA_WIDTH),
    .ACCUM_DATA_WIDTH (ACCUM_DATA_WIDTH)
  ) u_mult (
    .clock     (clock),
    .reset     (reset),
    .enable    (bus.enable),
    .data_in   (bus.data_in),
    .weight_in (bus.weight_in),
    .prod_r    (prod_r)
  );

  // A start pulse re-labels the current sample as tap 0.
  always_comb begin
    eff_tap    = bus.start ? '0 : count_reg;
    count_next = COUNT_SLOAD_BITWIDTH'(tap_after(int'(eff_tap), KERNEL_TAPS));
  end

  always_comb begin
`ifdef MAC_BIAS_EN
    load_value = prod_r + bus.bias_in;
`else
    load_value = prod_r;
`endif
    acc_next = sload_r ? load_value : acc_reg + prod_r;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg  <= '0;
      sload_r    <= 1'b0;
      acc_reg    <= '0;
      result_reg <= '0;
    end else if (bus.enable) begin
      count_reg  <= count_next;
      sload_r    <= (eff_tap == '0);
      acc_reg    <= acc_next;
      result_reg <= acc_reg;
    end
  end

  assign bus.result      = result_reg;
  assign bus.count_sload = count_reg;
endmodule

// File: tb/tb_mac_accum_param_3.sv
// Directed bench for mac_accum_param_3 with a window-level reference model;
// define MAC_BIAS_EN to also exercise the bias path.
module tb_mac_accum_param_3;
  import mac_accum_param_3_pkg::*;

  localparam int DW = 16;
  localparam int AW = 32;
  localparam int CW = 5;
  localparam int K  = 25;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mac_accum_param_3_if #(.DATA_WIDTH(DW), .ACCUM_DATA_WIDTH(AW), .COUNT_SLOAD_BITWIDTH(CW)) bus ();

  mac_accum_param_3 #(
    .DATA_WIDTH(DW), .ACCUM_DATA_WIDTH(AW), .COUNT_SLOAD_BITWIDTH(CW), .KERNEL_TAPS(K)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  // Reference model: products of the current and last completed window, by tap.
  logic signed [AW-1:0] cur  [K];
  logic signed [AW-1:0] prev [K];
  int   m_tap = 0;
  bit   live  = 1'b0;
  bit   dc    = 1'b0;

  always @(posedge clock) begin
    int eff;
    logic signed [AW-1:0] p;
    if (reset) begin
      m_tap = 0;
      dc    = 1'b0;
      live  = 1'b1;
      for (int k = 0; k < K; k++) begin
        cur[k]  = '0;
        prev[k] = '0;
      end
    end else if (live && bus.enable) begin
      eff = bus.start ? 0 : m_tap;
      if (bus.start && m_tap != 0) dc = 1'b1;
      if (eff == 0) for (int k = 0; k < K; k++) cur[k] = '0;
      p = AW'(bus.data_in) * AW'(bus.weight_in);
`ifdef MAC_BIAS_EN
      if (eff == 0) p = p + bus.bias_in;
`endif
      cur[eff] = p;
      if (eff == K - 1) begin
        for (int k = 0; k < K; k++) begin
          prev[k] = cur[k];
          cur[k]  = '0;
        end
      end
      m_tap = (eff == K - 1) ? 0 : eff + 1;
      if (m_tap == 3) dc = 1'b0;
    end
  end

  // Result seen at count c holds every product sampled up to tap c-3 (mod K).
  function automatic logic [AW-1:0] exp_result(input int c);
    logic [AW-1:0] s = '0;
    if (c >= 3) begin
      for (int k = 0; k < c - 2; k++) s += cur[k];
    end else begin
      for (int k = 0; k < K - 2 + c; k++) s += prev[k];
    end
    return s;
  endfunction

  always @(negedge clock) begin
    if (live) begin
      check("count_model", 32'(bus.count_sload), 32'(m_tap));
      if (!dc) check("result_model", bus.result, exp_result(m_tap));
    end
  end

  task automatic tick(input bit en, input bit st, input int d, input int w);
    bus.enable    = en;
    bus.start     = st;
    bus.data_in   = DW'(d);
    bus.weight_in = DW'(w);
    @(posedge clock);
    #2;
  endtask

  task automatic feed(input int n, input int d, input int w);
    repeat (n) tick(1'b1, 1'b0, d, w);
  endtask

  task automatic lit(input string name, input int exp_cnt, input logic [31:0] exp);
    $display("txn %s: count_sload=%0d result=%0d", name, bus.count_sload, $signed(bus.result));
    check({name, "_count"}, 32'(bus.count_sload), 32'(exp_cnt));
    check(name, bus.result, exp);
  endtask

  initial begin
    reset = 1'b1;
`ifdef MAC_BIAS_EN
    bus.bias_in = '0;
`endif
    tick(1'b0, 1'b0, 0, 0);
    tick(1'b0, 1'b0, 0, 0);
    reset = 1'b0;
    lit("reset_state", 0, 32'h0000_0000);

    // Windows of ones
    feed(27, 1, 1);
    lit("ones_w1", 2, 32'h0000_0019);
    feed(25, 1, 1);
    lit("ones_w2", 2, 32'h0000_0019);

    // Negative products
    feed(23, -2, 3);
    feed(27, -2, 3);
    lit("neg_window", 2, 32'hFFFF_FF6A);

    // Ramp with a 4-cycle stall before tap 10
    feed(23, 0, 0);
    for (int n = 0; n < K; n++) begin
      if (n == 10) begin
        repeat (4) tick(1'b0, 1'b0, n, 1);
        lit("stall_frozen", 10, 32'd28);
      end
      tick(1'b1, 1'b0, n, 1);
    end
    feed(2, 0, 1);
    lit("ramp_stall", 2, 32'd300);

    // Start pulse at tap 12 discards the partial window
    feed(10, 7, 7);
    tick(1'b1, 1'b1, 2, 2);
    feed(24, 2, 2);
    feed(2, 2, 2);
    lit("start_resync", 2, 32'd100);

    // Reset mid-window
    feed(5, 1, 1);
    reset = 1'b1;
    tick(1'b1, 1'b0, 1, 1);
    reset = 1'b0;
    lit("mid_reset", 0, 32'h0000_0000);
    feed(27, 1, 1);
    lit("after_reset", 2, 32'h0000_0019);

`ifdef MAC_BIAS_EN
    bus.bias_in = -32'sd30;
    feed(23, 1, 1);
    feed(27, 1, 1);
    lit("bias_window", 2, 32'hFFFF_FFFB);
`endif

    // Start while disabled must be ignored
    tick(1'b0, 1'b1, 5, 5);
    tick(1'b0, 1'b1, 5, 5);
    lit("start_disabled", 2, exp_result(2));
    feed(3, 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
